// File: rtl/uart_rx_ext_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } rx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    localparam int unsigned ERR_FRAME  = 0;
    localparam int unsigned ERR_PARITY = 1;

    // Encoding 3 is reserved and behaves as no parity.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_ext_edge2en.sv
// Edge-to-enable converter: one-cycle pulse on the selected edge of sig_i.
module edge2en #(
    parameter bit FALL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sig_i,
    output logic en_o
);

    logic sig_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) sig_q <= 1'b1;
        else          sig_q <= sig_i;
    end

    assign en_o = FALL ? (sig_q & ~sig_i) : (~sig_q & sig_i);

endmodule

// File: rtl/uart_rx_ext_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             rd_ok, wr_ok;

    assign empty_o   = (level_q == '0);
    assign full_o    = (level_q == (AW+1)'(DEPTH));
    assign level_o   = level_q;
    assign rd_data_o = mem[rd_ptr_q];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign rd_ok = rd_en_i & ~empty_o;
    assign wr_ok = wr_en_i & (~full_o | rd_ok);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr_q] <= wr_data_i;
                wr_ptr_q      <= wr_ptr_q + AW'(1);
            end
            if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver with runtime parity/stop config and RX FIFO.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          uart_rx_i,
    input  logic [31:0]                   uart_rx_baud_div_i,
    input  logic [1:0]                    uart_rx_parity_i,
    input  logic                          uart_rx_stop2_i,
    output logic [DATA_WIDTH-1:0]         uart_rx_data_o,
    output logic [1:0]                    uart_rx_err_o,
    output logic                          uart_rx_data_vld_o,
    input  logic                          uart_rx_data_rdy_i,
    output logic [$clog2(FIFO_DEPTH):0]   uart_rx_level_o,
    output logic                          uart_rx_ovf_o,
    input  logic                          uart_rx_ovf_clr_i,
    output logic                          uart_rx_break_o
);

    localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_t             state_q, state_d;
    logic                  rx_s1, rx_s2, start_fall;
    logic [31:0]           cnt_q, div_q;
    logic                  tick_q;
    logic [1:0]            par_q;
    logic                  stop2_q;
    logic [DATA_WIDTH-1:0] sh_q;
    logic [BIT_W-1:0]      bit_cnt_q;
    logic                  perr_q, ferr_q;
    logic                  finish;
    logic [1:0]            fin_err;
    logic                  fin_brk;
    logic                  push_q;
    logic [DATA_WIDTH-1:0] push_data_q;
    logic [1:0]            push_err_q;
    logic                  brk_q;
    logic                  ovf_q;
    logic                  fifo_full, fifo_empty, pop;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= uart_rx_i;
            rx_s2 <= rx_s1;
        end
    end

    edge2en #(.FALL(1'b1)) u_start_edge (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .sig_i   (rx_s2),
        .en_o    (start_fall)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        finish  = 1'b0;
        fin_err = '0;
        fin_err[ERR_FRAME]  = ferr_q | ~rx_s2;
        fin_err[ERR_PARITY] = perr_q;
        case (state_q)
            IDLE:   if (start_fall) state_d = START;
            START:  if (tick_q) state_d = rx_s2 ? IDLE : DATA;
            DATA:   if (tick_q && bit_cnt_q == BIT_W'(DATA_WIDTH-1))
                        state_d = parity_enabled(par_q) ? PARITY : STOP1;
            PARITY: if (tick_q) state_d = STOP1;
            STOP1:  if (tick_q) begin
                        state_d = stop2_q ? STOP2 : IDLE;
                        finish  = ~stop2_q;
                    end
            STOP2:  if (tick_q) begin
                        state_d = IDLE;
                        finish  = 1'b1;
                    end
            default: state_d = IDLE;
        endcase
    end

`ifdef UART_RX_BREAK_DET_EN
    // Cleared by any high sample in parity or STOP1; data-zero is checked at finish.
    logic brk_cand_q;
    assign fin_brk = brk_cand_q & ~(|sh_q) & ((state_q == STOP2) | ~rx_s2);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) brk_cand_q <= 1'b0;
        else if (tick_q) begin
            if (state_q == START) brk_cand_q <= 1'b1;
            else if ((state_q == PARITY || state_q == STOP1) && rx_s2) brk_cand_q <= 1'b0;
        end
    end
`else
    assign fin_brk = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q       <= '0;
            div_q       <= '0;
            tick_q      <= 1'b0;
            par_q       <= '0;
            stop2_q     <= 1'b0;
            sh_q        <= '0;
            bit_cnt_q   <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            push_err_q  <= '0;
            brk_q       <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                if (start_fall) begin
                    cnt_q   <= uart_rx_baud_div_i >> 1;
                    div_q   <= uart_rx_baud_div_i;
                    par_q   <= uart_rx_parity_i;
                    stop2_q <= uart_rx_stop2_i;
                end
            end else begin
                cnt_q <= (cnt_q == div_q) ? '0 : cnt_q + 32'd1;
            end
            tick_q <= (state_q != IDLE) && (cnt_q == div_q);

            if (tick_q) begin
                case (state_q)
                    START: if (!rx_s2) begin
                        sh_q      <= '0;
                        bit_cnt_q <= '0;
                        perr_q    <= 1'b0;
                        ferr_q    <= 1'b0;
                    end
                    DATA: begin
                        sh_q      <= {rx_s2, sh_q[DATA_WIDTH-1:1]};
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    end
                    PARITY: perr_q <= ((^sh_q) ^ rx_s2) != (par_q == PAR_ODD);
                    STOP1, STOP2: if (!rx_s2) ferr_q <= 1'b1;
                    default: ;
                endcase
            end

            push_q <= finish & ~fin_brk;
            brk_q  <= finish & fin_brk;
            if (finish) begin
                push_data_q <= sh_q;
                push_err_q  <= fin_err;
            end
        end
    end

    assign pop = ~fifo_empty & uart_rx_data_rdy_i;

    sync_fifo #(
        .WIDTH (DATA_WIDTH + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .wr_en_i   (push_q),
        .wr_data_i ({push_err_q, push_data_q}),
        .rd_en_i   (uart_rx_data_rdy_i),
        .rd_data_o ({uart_rx_err_o, uart_rx_data_o}),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (uart_rx_level_o)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                        ovf_q <= 1'b0;
        else if (push_q & fifo_full & ~pop)  ovf_q <= 1'b1;
        else if (uart_rx_ovf_clr_i)          ovf_q <= 1'b0;
    end

    assign uart_rx_ovf_o      = ovf_q;
    assign uart_rx_data_vld_o = ~fifo_empty;
    assign uart_rx_break_o    = brk_q;

endmodule
